// File: rtl/dmem_responder.sv
// Data-memory responder: word load/store over valid/ready request and response
// channels, with a fixed access latency and error flagging for bad addresses.
module dmem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [30:0] DEPTH_W  = 31'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam bit          SINGLE   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg,     state_next;
    logic [3:0]  counter_reg,   counter_next;
    logic        req_ready_reg, req_ready_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg,   rsp_err_next;
    logic        lat_write_reg, lat_write_next;
    logic [31:0] lat_addr_reg,  lat_addr_next;
    logic [31:0] lat_wdata_reg, lat_wdata_next;

    logic [DEPTH-1:0][31:0] mem_q;

    logic        accept;
    logic        commit;
    logic        mem_we;
    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [29:0] word_idx;
    logic        addr_err;
    logic [31:0] rd_data;

    assign accept = (state_reg == IDLE) && req_valid && req_ready_reg;

    // With a single-cycle latency the commit happens on the accept edge itself,
    // so the operands come straight from the request inputs in that case.
    assign cur_write = (state_reg == IDLE) ? req_write : lat_write_reg;
    assign cur_addr  = (state_reg == IDLE) ? req_addr  : lat_addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? req_wdata : lat_wdata_reg;

    assign word_idx = cur_addr[31:2];
    assign addr_err = (cur_addr[1:0] != 2'b00) || ({1'b0, word_idx} >= DEPTH_W);
    assign rd_data  = mem_q[word_idx[IDX_W-1:0]];

    assign commit = (SINGLE && accept) || ((state_reg == WAIT) && (counter_reg == 4'd1));
    assign mem_we = commit && cur_write && !addr_err;

    // Word storage: every word is cleared by reset, so each is its own register.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [31:0] word_reg;

            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (mem_we && (word_idx == 30'(gi))) begin
                    word_reg <= cur_wdata;
                end
            end

            assign mem_q[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            counter_reg   <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            lat_write_reg <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            lat_write_reg <= lat_write_next;
            lat_addr_reg  <= lat_addr_next;
            lat_wdata_reg <= lat_wdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        counter_next   = counter_reg;
        req_ready_next = req_ready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        lat_write_next = lat_write_reg;
        lat_addr_next  = lat_addr_reg;
        lat_wdata_next = lat_wdata_reg;

        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                if (accept) begin
                    lat_write_next = req_write;
                    lat_addr_next  = req_addr;
                    lat_wdata_next = req_wdata;
                    counter_next   = CNT_INIT;
                    req_ready_next = 1'b0;
                    state_next     = SINGLE ? RESP : WAIT;
                end
            end
            WAIT: begin
                counter_next = counter_reg - 4'd1;
                if (counter_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_reg && rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b0;
                    req_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                req_ready_next = 1'b0;
            end
        endcase

        // Load data is the pre-write array contents; stores and errors return 0.
        if (commit) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = addr_err;
            rsp_rdata_next = (!addr_err && !cur_write) ? rd_data : 32'h0;
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
